// File: rtl/memory_game_pkg.sv
// memory_game_pkg: shared types and constants for the memory-game datapath.
// Revision: 1.0
`default_nettype none

package memory_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INIT    = 2'd1,
    ST_SHUFFLE = 2'd2,
    ST_DONE    = 2'd3
  } shuf_state_t;

  localparam int          CARD_COLOR_W = 12;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  localparam logic [CARD_COLOR_W-1:0] PALETTE [0:15] = '{
    12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
    12'hF0F, 12'h0FF, 12'hF80, 12'h8F0,
    12'h08F, 12'hF08, 12'h80F, 12'h0F8,
    12'hFFF, 12'h888, 12'h840, 12'h48C
  };

  // Smallest all-ones value covering c, i.e. 2^clog2(c+1)-1 for c >= 1.
  function automatic logic [5:0] fy_mask(input logic [5:0] c);
    logic [5:0] m;
    m = c;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit right-shifting Galois LFSR.
// Revision: 1.0
`default_nettype none

module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= SEED;
    else     q <= (q >> 1) ^ (q[0] ? TAPS : 16'h0000);
  end

endmodule

`default_nettype wire

// File: rtl/card_color_shuffler.sv
// card_color_shuffler: Fisher-Yates shuffle of NUM_CARDS/2 card pairs with a
// registered slot read port and palette lookup. Revision: 1.0
`default_nettype none

module card_color_shuffler
  import memory_game_pkg::*;
#(
  parameter int          NUM_CARDS = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         IDX_W     = $clog2(NUM_CARDS),
  localparam int         PAIR_W    = $clog2(NUM_CARDS / 2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [PAIR_W-1:0]       rd_pair,
  output logic [CARD_COLOR_W-1:0] rd_color
);

  shuf_state_t       state, state_next;
  logic [15:0]       lfsr;
  logic [IDX_W-1:0]  cnt;
  logic [PAIR_W-1:0] slots [NUM_CARDS];

  logic [5:0]        cnt_ext, rnd, swap_idx_ext;
  logic [IDX_W-1:0]  swap_idx;
  logic [PAIR_W-1:0] sel_pair;
  logic [3:0]        pal_idx;
  logic              unused_bits;

  lfsr16 #(
    .SEED (LFSR_SEED),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  // Fold out-of-range draws back into 0..cnt with one subtraction.
  assign cnt_ext      = 6'(cnt);
  assign rnd          = lfsr[5:0] & fy_mask(cnt_ext);
  assign swap_idx_ext = (rnd > cnt_ext) ? (rnd - cnt_ext - 6'd1) : rnd;
  assign swap_idx     = swap_idx_ext[IDX_W-1:0];
  assign unused_bits  = ^{lfsr[15:6], swap_idx_ext[5:IDX_W]};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_INIT;
      ST_INIT:    state_next = ST_SHUFFLE;
      ST_SHUFFLE: if (cnt == IDX_W'(1)) state_next = ST_DONE;
      ST_DONE:    if (start) state_next = ST_INIT;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_INIT) || (state == ST_SHUFFLE);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || state == ST_INIT) begin
      for (int i = 0; i < NUM_CARDS; i++) slots[i] <= PAIR_W'(i >> 1);
    end else if (state == ST_SHUFFLE) begin
      slots[cnt]      <= slots[swap_idx];
      slots[swap_idx] <= slots[cnt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                     cnt <= '0;
    else if (state == ST_INIT)   cnt <= IDX_W'(NUM_CARDS - 1);
    else if (state == ST_SHUFFLE) cnt <= cnt - IDX_W'(1);
  end

  always_comb begin
    sel_pair = '0;
    if (int'(rd_idx) < NUM_CARDS) sel_pair = slots[rd_idx];
  end

  assign pal_idx = 4'(sel_pair);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pair  <= '0;
      rd_color <= PALETTE[0];
    end else begin
      rd_pair  <= sel_pair;
      rd_color <= PALETTE[pal_idx];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_card_color_shuffler.sv
// tb_card_color_shuffler: directed checks of the card shuffler against an
// LFSR/Fisher-Yates reference model. Revision: 1.0
`default_nettype none

module tb_card_color_shuffler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  rd_idx = '0;
  logic        busy, done;
  logic [2:0]  rd_pair;
  logic [11:0] rd_color;

  int tests = 0;
  int fails = 0;

  logic [15:0] m_lfsr;
  logic [2:0]  exp_lay  [16];
  logic [2:0]  prev_exp [16];
  logic [2:0]  got_lay  [16];
  logic [11:0] got_col  [16];
  logic [11:0] pal      [16] = '{
    12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hF0F, 12'h0FF, 12'hF80, 12'h8F0,
    12'h08F, 12'hF08, 12'h80F, 12'h0F8, 12'hFFF, 12'h888, 12'h840, 12'h48C
  };

  always #5 clk = ~clk;

  card_color_shuffler #(
    .NUM_CARDS (16),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_idx   (rd_idx),
    .rd_pair  (rd_pair),
    .rd_color (rd_color)
  );

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lstep(m_lfsr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lk is the model LFSR value just after the edge that sampled start.
  task automatic compute_model(input logic [15:0] lk);
    logic [15:0] v;
    int m, r, j;
    logic [2:0] t;
    for (int i = 0; i < 16; i++) exp_lay[i] = 3'(i / 2);
    v = lk;
    for (int c = 15; c >= 1; c--) begin
      v = lstep(v);
      m = 1;
      while (m < c) m = m * 2 + 1;
      r = int'(v) & m;
      j = (r > c) ? r - (c + 1) : r;
      t = exp_lay[c];
      exp_lay[c] = exp_lay[j];
      exp_lay[j] = t;
    end
  endtask

  task automatic read_layout();
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      tick();
      got_lay[i] = rd_pair;
      got_col[i] = rd_color;
    end
  endtask

  task automatic pulse_start(output logic [15:0] lk);
    start = 1'b1;
    tick();
    start = 1'b0;
    lk = m_lfsr;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (rd_pair !== 3'd0 || rd_color !== 12'hF00) begin
      fails++;
      $display("FAIL reset_read: rd_pair=%0d rd_color=%h, required 0/F00", rd_pair, rd_color);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: busy=%b done=%b, required 0/0", busy, done);
    end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      tick();
      tests++;
      if (rd_pair !== 3'(i / 2) || rd_color !== pal[i / 2]) begin
        fails++;
        $display("FAIL reset_identity slot %0d: pair=%0d color=%h, required %0d/%h",
                 i, rd_pair, rd_color, i / 2, pal[i / 2]);
      end
    end
  endtask

  task automatic test_start_timing();
    logic [15:0] lk;
    int bad_edge;
    bad_edge = -1;
    repeat (20) tick();
    pulse_start(lk);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL start_busy: busy=%b done=%b, required 1/0", busy, done);
    end
    for (int e = 1; e <= 15; e++) begin
      tick();
      if ((busy !== 1'b1 || done !== 1'b0) && bad_edge < 0) bad_edge = e;
    end
    tests++;
    if (bad_edge >= 0) begin
      fails++;
      $display("FAIL busy_window: flags changed at edge +%0d, required busy through +15", bad_edge);
    end
    tick();
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_latency: at +16 done=%b busy=%b, required 1/0", done, busy);
    end
    compute_model(lk);
    read_layout();
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (got_lay[i] !== exp_lay[i]) begin
        fails++;
        $display("FAIL layout slot %0d: got %0d, required %0d", i, got_lay[i], exp_lay[i]);
      end
    end
  endtask

  task automatic test_invariant();
    logic [15:0] lk;
    int n, cnt_bad, col_bad, mdl_bad;
    int occ [8];
    for (int s = 0; s < 50; s++) begin
      repeat ($urandom_range(0, 7)) tick();
      pulse_start(lk);
      wait_done(n);
      tests++;
      if (n != 16) begin
        fails++;
        $display("FAIL inv_latency run %0d: done after %0d edges, required 16", s, n);
      end
      compute_model(lk);
      read_layout();
      for (int p = 0; p < 8; p++) occ[p] = 0;
      col_bad = 0;
      mdl_bad = 0;
      for (int i = 0; i < 16; i++) begin
        occ[got_lay[i]]++;
        if (got_col[i] !== pal[got_lay[i]]) col_bad++;
        if (got_lay[i] !== exp_lay[i]) mdl_bad++;
      end
      cnt_bad = 0;
      for (int p = 0; p < 8; p++) if (occ[p] != 2) cnt_bad++;
      tests++;
      if (cnt_bad != 0) begin
        fails++;
        $display("FAIL inv_pairs run %0d: %0d pair ids not exactly twice, required 0", s, cnt_bad);
      end
      tests++;
      if (col_bad != 0) begin
        fails++;
        $display("FAIL inv_color run %0d: %0d slots with wrong colour, required 0", s, col_bad);
      end
      tests++;
      if (mdl_bad != 0) begin
        fails++;
        $display("FAIL inv_model run %0d: %0d slots differ from model, required 0", s, mdl_bad);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [15:0] lk;
    int n, mdl_bad;
    tick();
    pulse_start(lk);
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    tests++;
    if (n + 5 != 16) begin
      fails++;
      $display("FAIL busy_start_latency: done at +%0d, required +16", n + 5);
    end
    compute_model(lk);
    read_layout();
    mdl_bad = 0;
    for (int i = 0; i < 16; i++) if (got_lay[i] !== exp_lay[i]) mdl_bad++;
    tests++;
    if (mdl_bad != 0) begin
      fails++;
      $display("FAIL busy_start_layout: %0d slots differ from single-start model, required 0", mdl_bad);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] lk;
    int n, bad;
    pulse_start(lk);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL midreset_flags: busy=%b done=%b, required 0/0", busy, done);
    end
    read_layout();
    bad = 0;
    for (int i = 0; i < 16; i++) if (got_lay[i] !== 3'(i / 2)) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL midreset_identity: %0d slots not identity, required 0", bad);
    end
    pulse_start(lk);
    wait_done(n);
    tests++;
    if (n != 16) begin
      fails++;
      $display("FAIL midreset_latency: done after %0d edges, required 16", n);
    end
    compute_model(lk);
    read_layout();
    bad = 0;
    for (int i = 0; i < 16; i++) if (got_lay[i] !== exp_lay[i]) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL midreset_model: %0d slots differ from model, required 0", bad);
    end
  endtask

  task automatic test_restart_from_done();
    logic [15:0] lk;
    logic [2:0]  old_lay [16];
    int n, bad, mdl_diff, dut_diff;
    for (int i = 0; i < 16; i++) begin
      prev_exp[i] = exp_lay[i];
      old_lay[i]  = got_lay[i];
    end
    repeat (3) tick();
    pulse_start(lk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_flags: done=%b busy=%b, required 0/1", done, busy);
    end
    wait_done(n);
    tests++;
    if (n != 16) begin
      fails++;
      $display("FAIL restart_latency: done after %0d edges, required 16", n);
    end
    compute_model(lk);
    read_layout();
    bad = 0;
    mdl_diff = 0;
    dut_diff = 0;
    for (int i = 0; i < 16; i++) begin
      if (got_lay[i] !== exp_lay[i]) bad++;
      if (exp_lay[i] !== prev_exp[i]) mdl_diff++;
      if (got_lay[i] !== old_lay[i]) dut_diff++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL restart_model: %0d slots differ from model, required 0", bad);
    end
    if (mdl_diff != 0) begin
      tests++;
      if (dut_diff == 0) begin
        fails++;
        $display("FAIL restart_changed: layout unchanged (0 slots differ), required %0d", mdl_diff);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_timing();
    test_invariant();
    test_start_while_busy();
    test_reset_mid();
    test_restart_from_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
